// File: rtl/hazard_controller_pkg.sv
// rtl/hazard_controller_pkg.sv - shared pipeline types for the hazard controller
package pipeline_pkg;

  // Writeback source selected in E; WB_LD marks a load
  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_LD  = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // E-stage operand source
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_sel_e;

  // Memory-wait FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ERR  = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_controller_if.sv
// rtl/hazard_controller_if.sv - pipeline <-> hazard controller signal bundle
interface hazard_controller_if;
  import pipeline_pkg::*;

  logic [4:0]  rs1_addrD, rs2_addrD;
  logic [4:0]  rs1_addrE, rs2_addrE;
  logic [4:0]  rd_addrE, rd_addrM, rd_addrW;
  logic        rd_wrenE, rd_wrenM, rd_wrenW;
  wb_sel_e     wb_selE;
  logic        pc_selE;
  logic        mem_reqM;
  logic        mem_ackM;

  logic        StallF, StallD, StallE, StallM, StallW;
  logic        FlushD, FlushE, FlushM, FlushW;
  fwd_sel_e    fwd_aE, fwd_bE;
  logic        o_mem_err;
  logic [31:0] o_stall_cnt;

  // Pipeline side: supplies stage state, receives hazard controls
  modport master (
    output rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE,
           rd_addrE, rd_addrM, rd_addrW, rd_wrenE, rd_wrenM, rd_wrenW,
           wb_selE, pc_selE, mem_reqM, mem_ackM,
    input  StallF, StallD, StallE, StallM, StallW,
           FlushD, FlushE, FlushM, FlushW, fwd_aE, fwd_bE,
           o_mem_err, o_stall_cnt
  );

  // Hazard controller side
  modport slave (
    input  rs1_addrD, rs2_addrD, rs1_addrE, rs2_addrE,
           rd_addrE, rd_addrM, rd_addrW, rd_wrenE, rd_wrenM, rd_wrenW,
           wb_selE, pc_selE, mem_reqM, mem_ackM,
    output StallF, StallD, StallE, StallM, StallW,
           FlushD, FlushE, FlushM, FlushW, fwd_aE, fwd_bE,
           o_mem_err, o_stall_cnt
  );

endinterface

// File: rtl/hazard_controller_fwd.sv
// rtl/hazard_controller_fwd.sv - forwarding select for one E-stage operand
module forward_unit
  import pipeline_pkg::*;
(
  input  logic [4:0] rs_addr_i,
  input  logic [4:0] rd_addr_m_i,
  input  logic       rd_wren_m_i,
  input  logic [4:0] rd_addr_w_i,
  input  logic       rd_wren_w_i,
  output fwd_sel_e   fwd_o
);

  // Youngest producer (M) wins over W; x0 is hardwired zero and never forwarded
  always_comb begin
    fwd_o = FWD_RF;
    if (rd_wren_m_i && (rd_addr_m_i != 5'd0) && (rd_addr_m_i == rs_addr_i)) begin
      fwd_o = FWD_M;
    end else if (rd_wren_w_i && (rd_addr_w_i != 5'd0) && (rd_addr_w_i == rs_addr_i)) begin
      fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - stall/flush/forward control with memory-wait FSM
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter  int TIMEOUT = 16,
  localparam int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  hazard_controller_if.slave hz
);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mem_err_q;
  logic [31:0]      stall_cnt_q;

  logic mem_busy, lwstall;
  logic stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_m, flush_w;

  forward_unit u_fwd_a (
    .rs_addr_i   (hz.rs1_addrE),
    .rd_addr_m_i (hz.rd_addrM),
    .rd_wren_m_i (hz.rd_wrenM),
    .rd_addr_w_i (hz.rd_addrW),
    .rd_wren_w_i (hz.rd_wrenW),
    .fwd_o       (hz.fwd_aE)
  );

  forward_unit u_fwd_b (
    .rs_addr_i   (hz.rs2_addrE),
    .rd_addr_m_i (hz.rd_addrM),
    .rd_wren_m_i (hz.rd_wrenM),
    .rd_addr_w_i (hz.rd_addrW),
    .rd_wren_w_i (hz.rd_wrenW),
    .fwd_o       (hz.fwd_bE)
  );

  // Hazard conditions; mem_busy is qualified by reset so a held request
  // cannot keep the pipe frozen while the FSM is being reset
  always_comb begin
    lwstall  = (hz.wb_selE == WB_LD) && hz.rd_wrenE && (hz.rd_addrE != 5'd0) &&
               ((hz.rd_addrE == hz.rs1_addrD) || (hz.rd_addrE == hz.rs2_addrD));
    mem_busy = i_rst_n &&
               (((state_q == IDLE) && hz.mem_reqM && !hz.mem_ackM) ||
                ((state_q == WAIT) && !hz.mem_ackM));
  end

  // Prioritised stall/flush generation: ERR > mem wait > redirect > load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    flush_w = 1'b0;
    if (state_q == ERR) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      flush_m = 1'b1;
      flush_w = 1'b1;
    end else if (mem_busy) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.pc_selE) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (lwstall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Memory-wait FSM next state and wait counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_busy) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (hz.mem_ackM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = ERR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ERR: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, error pulse and saturating stall-cycle counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= (state_d == ERR);
      if (stall_f && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign hz.StallF      = stall_f;
  assign hz.StallD      = stall_d;
  assign hz.StallE      = stall_e;
  assign hz.StallM      = stall_m;
  assign hz.StallW      = 1'b0;
  assign hz.FlushD      = flush_d;
  assign hz.FlushE      = flush_e;
  assign hz.FlushM      = flush_m;
  assign hz.FlushW      = flush_w;
  assign hz.o_mem_err   = mem_err_q;
  assign hz.o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed self-checking bench for hazard_controller
`timescale 1ns/1ps
module tb_hazard_controller;
  import pipeline_pkg::*;

  logic i_clk;
  logic i_rst_n;
  hazard_controller_if hif ();

  hazard_controller #(.TIMEOUT(4)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .hz      (hif.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // {StallF,StallD,StallE,StallM,StallW,FlushD,FlushE,FlushM,FlushW}
  wire [8:0] ctl = {hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.StallW,
                    hif.FlushD, hif.FlushE, hif.FlushM, hif.FlushW};

  localparam logic [8:0] CTL_NONE = 9'b00000_0000;
  localparam logic [8:0] CTL_ERR  = 9'b11100_0011;
  localparam logic [8:0] CTL_BUSY = 9'b11110_0001;
  localparam logic [8:0] CTL_PC   = 9'b00000_1100;
  localparam logic [8:0] CTL_LW   = 9'b11000_0100;

  int          checks;
  int          errors;
  logic [31:0] exp_cnt;

  task automatic cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    hif.rs1_addrD = 5'd0; hif.rs2_addrD = 5'd0;
    hif.rs1_addrE = 5'd0; hif.rs2_addrE = 5'd0;
    hif.rd_addrE  = 5'd0; hif.rd_addrM  = 5'd0; hif.rd_addrW = 5'd0;
    hif.rd_wrenE  = 1'b0; hif.rd_wrenM  = 1'b0; hif.rd_wrenW = 1'b0;
    hif.wb_selE   = WB_ALU;
    hif.pc_selE   = 1'b0;
    hif.mem_reqM  = 1'b0;
    hif.mem_ackM  = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    clear_inputs();
    #2;
    checks++;
    if (ctl !== CTL_NONE) begin
      errors++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_NONE);
    end
    checks++;
    if ({hif.fwd_aE, hif.fwd_bE} !== 4'b0000) begin
      errors++; $display("FAIL reset_fwd: got %b%b want 0000", hif.fwd_aE, hif.fwd_bE);
    end
    checks++;
    if (hif.o_mem_err !== 1'b0 || hif.o_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL reset_regs: got err=%b cnt=%0d want err=0 cnt=0",
                         hif.o_mem_err, hif.o_stall_cnt);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    exp_cnt = 32'd0;
    cycle();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    hif.rd_addrM = 5'd5; hif.rd_wrenM = 1'b1; hif.rs1_addrE = 5'd5;
    hif.rd_addrW = 5'd5; hif.rd_wrenW = 1'b1;
    #2;
    checks++;
    if (hif.fwd_aE !== FWD_M || hif.fwd_bE !== FWD_RF) begin
      errors++; $display("FAIL fwd_m_priority: got a=%0d b=%0d want a=1 b=0", hif.fwd_aE, hif.fwd_bE);
    end
    hif.rd_addrM = 5'd0; hif.rs1_addrE = 5'd0;
    #2;
    checks++;
    if (hif.fwd_aE !== FWD_RF) begin
      errors++; $display("FAIL fwd_x0: got %0d want 0", hif.fwd_aE);
    end
    hif.rd_addrM = 5'd5; hif.rd_wrenM = 1'b0; hif.rs1_addrE = 5'd5; hif.rs2_addrE = 5'd5;
    #2;
    checks++;
    if (hif.fwd_aE !== FWD_W || hif.fwd_bE !== FWD_W) begin
      errors++; $display("FAIL fwd_w: got a=%0d b=%0d want a=2 b=2", hif.fwd_aE, hif.fwd_bE);
    end
    hif.rd_wrenW = 1'b0; hif.rd_wrenM = 1'b1; hif.rd_addrM = 5'd9; hif.rs2_addrE = 5'd9;
    #2;
    checks++;
    if (hif.fwd_aE !== FWD_RF || hif.fwd_bE !== FWD_M) begin
      errors++; $display("FAIL fwd_mixed: got a=%0d b=%0d want a=0 b=1", hif.fwd_aE, hif.fwd_bE);
    end
    checks++;
    if (ctl !== CTL_NONE) begin
      errors++; $display("FAIL fwd_no_stall: got %b want %b", ctl, CTL_NONE);
    end
    cycle();
  endtask

  task automatic test_load_use();
    clear_inputs();
    hif.wb_selE = WB_LD; hif.rd_addrE = 5'd7; hif.rd_wrenE = 1'b1; hif.rs2_addrD = 5'd7;
    #2;
    checks++;
    if (ctl !== CTL_LW) begin
      errors++; $display("FAIL lwstall: got %b want %b", ctl, CTL_LW);
    end
    cycle();
    exp_cnt++;
    // bubble now in E: load has moved on
    hif.wb_selE = WB_ALU; hif.rd_wrenE = 1'b0; hif.rd_addrE = 5'd0;
    #2;
    checks++;
    if (ctl !== CTL_NONE) begin
      errors++; $display("FAIL lwstall_one_cycle: got %b want %b", ctl, CTL_NONE);
    end
    cycle();
    hif.wb_selE = WB_LD; hif.rd_addrE = 5'd7; hif.rd_wrenE = 1'b1; hif.pc_selE = 1'b1;
    #2;
    checks++;
    if (ctl !== CTL_PC) begin
      errors++; $display("FAIL redirect_over_lw: got %b want %b", ctl, CTL_PC);
    end
    cycle();
    hif.pc_selE = 1'b0; hif.rd_addrE = 5'd0; hif.rs2_addrD = 5'd0;
    #2;
    checks++;
    if (ctl !== CTL_NONE) begin
      errors++; $display("FAIL lw_x0: got %b want %b", ctl, CTL_NONE);
    end
    cycle();
    checks++;
    if (hif.o_stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL lw_stall_cnt: got %0d want %0d", hif.o_stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    hif.mem_reqM = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #2;
      checks++;
      if (ctl !== CTL_BUSY) begin
        errors++; $display("FAIL mem_wait_cyc%0d: got %b want %b", i, ctl, CTL_BUSY);
      end
      cycle();
      exp_cnt++;
    end
    hif.mem_ackM = 1'b1;
    #2;
    checks++;
    if (ctl !== CTL_NONE) begin
      errors++; $display("FAIL mem_ack_release: got %b want %b", ctl, CTL_NONE);
    end
    cycle();
    // request acked in its first cycle: no stall at all
    #2;
    checks++;
    if (ctl !== CTL_NONE) begin
      errors++; $display("FAIL mem_same_cycle_ack: got %b want %b", ctl, CTL_NONE);
    end
    cycle();
    hif.mem_reqM = 1'b0;
    #2;
    checks++;
    if (ctl !== CTL_NONE) begin
      errors++; $display("FAIL mem_stray_ack: got %b want %b", ctl, CTL_NONE);
    end
    cycle();
    checks++;
    if (hif.o_stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL mem_stall_cnt: got %0d want %0d", hif.o_stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_deferred_redirect();
    clear_inputs();
    hif.mem_reqM = 1'b1; hif.pc_selE = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #2;
      checks++;
      if (ctl !== CTL_BUSY) begin
        errors++; $display("FAIL redirect_held_cyc%0d: got %b want %b", i, ctl, CTL_BUSY);
      end
      cycle();
      exp_cnt++;
    end
    hif.mem_ackM = 1'b1;
    #2;
    checks++;
    if (ctl !== CTL_PC) begin
      errors++; $display("FAIL redirect_release: got %b want %b", ctl, CTL_PC);
    end
    cycle();
    clear_inputs();
    cycle();
  endtask

  task automatic test_timeout();
    clear_inputs();
    hif.mem_reqM = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (ctl !== CTL_BUSY || hif.o_mem_err !== 1'b0) begin
        errors++; $display("FAIL timeout_wait_cyc%0d: got ctl=%b err=%b want ctl=%b err=0",
                           i, ctl, hif.o_mem_err, CTL_BUSY);
      end
      cycle();
      exp_cnt++;
    end
    hif.mem_reqM = 1'b0;
    #2;
    checks++;
    if (ctl !== CTL_ERR || hif.o_mem_err !== 1'b1) begin
      errors++; $display("FAIL timeout_err: got ctl=%b err=%b want ctl=%b err=1",
                         ctl, hif.o_mem_err, CTL_ERR);
    end
    cycle();
    exp_cnt++;
    #2;
    checks++;
    if (ctl !== CTL_NONE || hif.o_mem_err !== 1'b0) begin
      errors++; $display("FAIL timeout_back_idle: got ctl=%b err=%b want ctl=%b err=0",
                         ctl, hif.o_mem_err, CTL_NONE);
    end
    checks++;
    if (hif.o_stall_cnt !== exp_cnt) begin
      errors++; $display("FAIL timeout_stall_cnt: got %0d want %0d", hif.o_stall_cnt, exp_cnt);
    end
    cycle();
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    hif.mem_reqM = 1'b1;
    cycle();
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_NONE) begin
      errors++; $display("FAIL rst_mid_wait_ctl: got %b want %b", ctl, CTL_NONE);
    end
    checks++;
    if (hif.o_stall_cnt !== 32'd0 || hif.o_mem_err !== 1'b0) begin
      errors++; $display("FAIL rst_mid_wait_regs: got cnt=%0d err=%b want cnt=0 err=0",
                         hif.o_stall_cnt, hif.o_mem_err);
    end
    hif.mem_reqM = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    cycle();
    #2;
    checks++;
    if (ctl !== CTL_NONE || hif.o_stall_cnt !== 32'd0) begin
      errors++; $display("FAIL rst_recover: got ctl=%b cnt=%0d want ctl=%b cnt=0",
                         ctl, hif.o_stall_cnt, CTL_NONE);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_cnt = 32'd0;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_deferred_redirect();
    test_timeout();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
